pipe_ctrl: RTL and testbench

- Pipeline sequencer for the RV32IM core. It generates the stall_i, je_i and jump_addr_i inputs of the program counter, plus the stall and flush controls for the IF/ID and ID/EX registers.
- It arbitrates between four sources: EX-stage redirects, load-use hazards, multi-cycle mul/div, and instruction-memory wait.
- It also holds the PC after reset and holds redirects that arrive while the ROM is busy.

---
 rtl/pipe_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_pipe_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline sequencer for the RV32IM core.
// Drives the PC stall/jump controls and the IF/ID and ID/EX stall/flush controls.
// It arbitrates EX redirects, load-use hazards, multi-cycle mul/div and instruction-memory wait.
// All control outputs are combinational from the registered state and the current inputs.
module pipe_ctrl #(
    parameter int XLEN       = 32,
    parameter int BOOT_HOLD  = 2,
    parameter int MD_TIMEOUT = 64
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            ex_jump_req_i,
    input  logic [XLEN-1:0] ex_jump_addr_i,
    input  logic            load_use_i,
    input  logic            md_start_i,
    input  logic            md_done_i,
    input  logic            imem_ready_i,
    output logic            stall_o,
    output logic            je_o,
    output logic [XLEN-1:0] jump_addr_o,
    output logic            stall_id_o,
    output logic            stall_ex_o,
    output logic            flush_id_o,
    output logic            flush_ex_o,
    output logic            md_err_o,
    output logic [1:0]      state_o
);

    typedef enum logic [1:0] {
        BOOT    = 2'd0,
        RUN     = 2'd1,
        MD_WAIT = 2'd2
    } state_t;

    localparam int BOOT_W = (BOOT_HOLD > 1) ? $clog2(BOOT_HOLD) : 1;
    localparam int MD_W   = (MD_TIMEOUT > 1) ? $clog2(MD_TIMEOUT) : 1;

    // With no boot hold the sequencer comes out of reset directly in RUN,
    // so the first cycle after release already accepts traffic.
    localparam state_t RESET_STATE = (BOOT_HOLD == 0) ? RUN : BOOT;

    localparam logic [BOOT_W-1:0] BOOT_LAST = BOOT_W'((BOOT_HOLD > 0) ? BOOT_HOLD - 1 : 0);
    localparam logic [MD_W-1:0]   MD_LAST   = MD_W'((MD_TIMEOUT > 0) ? MD_TIMEOUT - 1 : 0);

    state_t            state;
    state_t            state_next;
    logic [BOOT_W-1:0] boot_cnt;
    logic [MD_W-1:0]   md_cnt;
    logic              pend_v;
    logic [XLEN-1:0]   pend_addr;
    logic              md_err;

    logic              boot_done;
    logic              md_expire;
    logic              md_exit;
    logic              run_free;
    logic              take_pend;
    logic              take_jump;
    logic              take_md;

    // Request decode shared by next-state, output and bookkeeping logic.
    always_comb begin
        boot_done = (boot_cnt == BOOT_LAST);
        md_expire = (md_cnt == MD_LAST) && !md_done_i;
        md_exit   = md_done_i || (md_cnt == MD_LAST);
        // RUN with no held redirect: fresh requests may be considered.
        run_free  = (state == RUN) && !pend_v;
        take_pend = (state == RUN) && pend_v;
        take_jump = run_free && ex_jump_req_i;
        // A jump squashes the mul/div on the wrong path; start+done together needs no wait.
        take_md   = run_free && !ex_jump_req_i && md_start_i && !md_done_i;
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= RESET_STATE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state selection.
    always_comb begin
        state_next = state;
        case (state)
            BOOT:    if (boot_done) state_next = RUN;
            RUN:     if (take_md)   state_next = MD_WAIT;
            MD_WAIT: if (md_exit)   state_next = RUN;
            default:                state_next = RESET_STATE;
        endcase
    end

    // Boot hold counter: counts cycles spent in BOOT after reset release.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            boot_cnt <= '0;
        end else if ((state == BOOT) && !boot_done) begin
            boot_cnt <= boot_cnt + 1'b1;
        end
    end

    // Mul/div wait counter: zeroed on issue, advanced every MD_WAIT cycle.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            md_cnt <= '0;
        end else if (take_md) begin
            md_cnt <= '0;
        end else if ((state == MD_WAIT) && !md_exit) begin
            md_cnt <= md_cnt + 1'b1;
        end
    end

    // Held redirect: captured when EX redirects while the ROM is busy, replayed when it frees up.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            pend_v    <= 1'b0;
            pend_addr <= '0;
        end else if (take_pend && imem_ready_i) begin
            pend_v    <= 1'b0;
        end else if (take_jump && !imem_ready_i) begin
            pend_v    <= 1'b1;
            pend_addr <= ex_jump_addr_i;
        end
    end

    // Sticky mul/div timeout flag, cleared only by reset.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            md_err <= 1'b0;
        end else if ((state == MD_WAIT) && md_expire) begin
            md_err <= 1'b1;
        end
    end

    // Control outputs from state and current requests, highest priority first.
    always_comb begin
        stall_o     = 1'b0;
        je_o        = 1'b0;
        jump_addr_o = '0;
        stall_id_o  = 1'b0;
        stall_ex_o  = 1'b0;
        flush_id_o  = 1'b0;
        flush_ex_o  = 1'b0;
        if (!rst_i) begin
            // Hold the PC and keep both pipe registers empty while in reset.
            stall_o    = 1'b1;
            flush_id_o = 1'b1;
            flush_ex_o = 1'b1;
        end else begin
            case (state)
                BOOT: begin
                    stall_o    = 1'b1;
                    flush_id_o = 1'b1;
                end
                RUN: begin
                    if (pend_v) begin
                        // Keep fetching nothing until the held redirect can be issued.
                        stall_o    = 1'b1;
                        flush_id_o = 1'b1;
                        if (imem_ready_i) begin
                            je_o        = 1'b1;
                            jump_addr_o = pend_addr;
                        end
                    end else if (ex_jump_req_i) begin
                        flush_id_o = 1'b1;
                        flush_ex_o = 1'b1;
                        if (imem_ready_i) begin
                            je_o        = 1'b1;
                            jump_addr_o = ex_jump_addr_i;
                        end else begin
                            stall_o = 1'b1;
                        end
                    end else if (md_start_i && !md_done_i) begin
                        stall_o    = 1'b1;
                        stall_id_o = 1'b1;
                        stall_ex_o = 1'b1;
                    end else if (load_use_i) begin
                        // Freeze fetch/decode one cycle and bubble the consumer out of EX.
                        stall_o    = 1'b1;
                        stall_id_o = 1'b1;
                        flush_ex_o = 1'b1;
                    end else if (!imem_ready_i) begin
                        stall_o    = 1'b1;
                        flush_id_o = 1'b1;
                    end
                end
                MD_WAIT: begin
                    // Release on the done cycle or on timeout so the pipe never deadlocks.
                    if (!md_exit) begin
                        stall_o    = 1'b1;
                        stall_id_o = 1'b1;
                        stall_ex_o = 1'b1;
                    end
                end
                default: begin
                    stall_o    = 1'b1;
                    flush_id_o = 1'b1;
                end
            endcase
        end
    end

    assign md_err_o = md_err;
    assign state_o  = state;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: scoreboard bench for pipe_ctrl with a behavioural reference model.
module tb_pipe_ctrl;

    localparam int XLEN = 32;
    localparam int BH   = 2;
    localparam int MDT  = 8;

    logic            clk = 1'b0;
    logic            rst_i = 1'b0;
    logic            ex_jump_req_i = 1'b0;
    logic [XLEN-1:0] ex_jump_addr_i = '0;
    logic            load_use_i = 1'b0;
    logic            md_start_i = 1'b0;
    logic            md_done_i = 1'b0;
    logic            imem_ready_i = 1'b1;
    logic            stall_o;
    logic            je_o;
    logic [XLEN-1:0] jump_addr_o;
    logic            stall_id_o;
    logic            stall_ex_o;
    logic            flush_id_o;
    logic            flush_ex_o;
    logic            md_err_o;
    logic [1:0]      state_o;

    always #5 clk = ~clk;

    pipe_ctrl #(
        .XLEN       (XLEN),
        .BOOT_HOLD  (BH),
        .MD_TIMEOUT (MDT)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .ex_jump_req_i  (ex_jump_req_i),
        .ex_jump_addr_i (ex_jump_addr_i),
        .load_use_i     (load_use_i),
        .md_start_i     (md_start_i),
        .md_done_i      (md_done_i),
        .imem_ready_i   (imem_ready_i),
        .stall_o        (stall_o),
        .je_o           (je_o),
        .jump_addr_o    (jump_addr_o),
        .stall_id_o     (stall_id_o),
        .stall_ex_o     (stall_ex_o),
        .flush_id_o     (flush_id_o),
        .flush_ex_o     (flush_ex_o),
        .md_err_o       (md_err_o),
        .state_o        (state_o)
    );

    typedef struct packed {
        logic            rstn;
        logic            stall;
        logic            je;
        logic [XLEN-1:0] addr;
        logic            sid;
        logic            sex;
        logic            fid;
        logic            fex;
        logic            err;
        logic [1:0]      st;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    logic [XLEN-1:0] pc_dut = '0;
    logic [XLEN-1:0] pc_exp = '0;

    // Reference model: boot cycles left, mul/div in flight and its age, held redirects, error flag.
    int              boot_left = BH;
    bit              md_busy   = 1'b0;
    int              md_age    = 0;
    logic [XLEN-1:0] pend_q[$];
    bit              err_m     = 1'b0;

    function automatic exp_t model_step(input bit rstn, input bit jreq, input logic [XLEN-1:0] a,
                                        input bit lu, input bit ms, input bit md, input bit rdy);
        exp_t e = '0;
        e.rstn = rstn;
        if (!rstn) begin
            e.stall = 1'b1;
            e.fid   = 1'b1;
            e.fex   = 1'b1;
            e.st    = 2'd0;
            boot_left = BH;
            md_busy   = 1'b0;
            md_age    = 0;
            pend_q.delete();
            err_m     = 1'b0;
            return e;
        end
        e.err = err_m;
        if (boot_left > 0) begin
            e.st    = 2'd0;
            e.stall = 1'b1;
            e.fid   = 1'b1;
            boot_left--;
        end else if (md_busy) begin
            e.st = 2'd2;
            if (md) begin
                md_busy = 1'b0;
            end else if (md_age == MDT - 1) begin
                md_busy = 1'b0;
                err_m   = 1'b1;
            end else begin
                e.stall = 1'b1;
                e.sid   = 1'b1;
                e.sex   = 1'b1;
                md_age++;
            end
        end else begin
            e.st = 2'd1;
            if (pend_q.size() > 0) begin
                e.stall = 1'b1;
                e.fid   = 1'b1;
                if (rdy) begin
                    e.je   = 1'b1;
                    e.addr = pend_q.pop_front();
                end
            end else if (jreq) begin
                e.fid = 1'b1;
                e.fex = 1'b1;
                if (rdy) begin
                    e.je   = 1'b1;
                    e.addr = a;
                end else begin
                    e.stall = 1'b1;
                    pend_q.push_back(a);
                end
            end else if (ms && !md) begin
                e.stall = 1'b1;
                e.sid   = 1'b1;
                e.sex   = 1'b1;
                md_busy = 1'b1;
                md_age  = 0;
            end else if (lu) begin
                e.stall = 1'b1;
                e.sid   = 1'b1;
                e.fex   = 1'b1;
            end else if (!rdy) begin
                e.stall = 1'b1;
                e.fid   = 1'b1;
            end
        end
        return e;
    endfunction

    function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] pc, input logic rstn,
                                                input logic je, input logic stall,
                                                input logic [XLEN-1:0] addr);
        if (!rstn)     return '0;
        else if (je)   return addr;
        else if (stall) return pc;
        else           return pc + 32'd4;
    endfunction

    task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL cyc=%0d %s got=%0h want=%0h", cyc, name, act, want);
        end
    endtask

    // One cycle of stimulus: drive just after the rising edge, record the expected response.
    task automatic drive(input int rstn, input int jreq, input logic [XLEN-1:0] a,
                         input int lu, input int ms, input int md, input int rdy);
        @(posedge clk);
        #1;
        rst_i          = (rstn != 0);
        ex_jump_req_i  = (jreq != 0);
        ex_jump_addr_i = a;
        load_use_i     = (lu != 0);
        md_start_i     = (ms != 0);
        md_done_i      = (md != 0);
        imem_ready_i   = (rdy != 0);
        sb.push_back(model_step(rst_i, ex_jump_req_i, a, load_use_i, md_start_i, md_done_i, imem_ready_i));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1, 0, $urandom, 0, 0, 0, 1);
    endtask

    // Monitor: compare every presented cycle against the oldest expectation.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            cyc++;
            chk("stall_o",     stall_o,     mon_e.stall);
            chk("je_o",        je_o,        mon_e.je);
            chk("jump_addr_o", jump_addr_o, mon_e.addr);
            chk("stall_id_o",  stall_id_o,  mon_e.sid);
            chk("stall_ex_o",  stall_ex_o,  mon_e.sex);
            chk("flush_id_o",  flush_id_o,  mon_e.fid);
            chk("flush_ex_o",  flush_ex_o,  mon_e.fex);
            chk("md_err_o",    md_err_o,    mon_e.err);
            chk("state_o",     state_o,     mon_e.st);
            chk("pc",          pc_dut,      pc_exp);
            pc_dut = next_pc(pc_dut, rst_i, je_o, stall_o, jump_addr_o);
            pc_exp = next_pc(pc_exp, mon_e.rstn, mon_e.je, mon_e.stall, mon_e.addr);
        end
    end

    initial begin
        // Reset, then boot hold and free-running fetch.
        repeat (3) drive(0, 0, 0, 0, 0, 0, 1);
        idle(5);
        // Jump with ROM ready, load-use on the wrong path.
        drive(1, 1, 32'h0000_0100, 1, 0, 0, 1);
        idle(2);
        // Jump while ROM busy for 3 cycles; second jump during the wait is dropped.
        drive(1, 1, 32'h0000_0200, 0, 0, 0, 0);
        drive(1, 1, 32'h0000_0300, 0, 0, 0, 0);
        drive(1, 0, $urandom, 0, 0, 0, 0);
        drive(1, 0, $urandom, 0, 0, 0, 1);
        idle(2);
        // Mul/div completing 5 cycles after issue.
        drive(1, 0, $urandom, 0, 1, 0, 1);
        repeat (4) drive(1, 0, $urandom, 0, 0, 0, 1);
        drive(1, 0, $urandom, 0, 0, 1, 1);
        idle(2);
        // Start and done together.
        drive(1, 0, $urandom, 0, 1, 1, 1);
        idle(2);
        // Mul/div that never completes.
        drive(1, 0, $urandom, 0, 1, 0, 1);
        repeat (10) drive(1, 0, $urandom, 0, 0, 0, 1);
        // Later traffic with the error flag set.
        drive(1, 1, 32'h0000_0040, 1, 0, 0, 1);
        drive(1, 0, $urandom, 1, 0, 0, 1);
        drive(1, 0, $urandom, 0, 0, 0, 0);
        idle(2);
        // Asynchronous reset in the middle of MD_WAIT.
        drive(1, 0, $urandom, 0, 1, 0, 1);
        repeat (2) drive(1, 0, $urandom, 0, 0, 0, 1);
        drive(0, 0, $urandom, 0, 0, 0, 1);
        idle(4);
        // Asynchronous reset with a redirect held.
        drive(1, 1, 32'h0000_0500, 0, 0, 0, 0);
        drive(1, 0, $urandom, 0, 0, 0, 0);
        drive(0, 0, $urandom, 0, 0, 0, 1);
        idle(5);
        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 79) != 0) ? 1 : 0,
                  ($urandom_range(0, 5) == 0) ? 1 : 0,
                  $urandom & 32'hFFFF_FFFC,
                  ($urandom_range(0, 4) == 0) ? 1 : 0,
                  ($urandom_range(0, 7) == 0) ? 1 : 0,
                  ($urandom_range(0, 4) == 0) ? 1 : 0,
                  ($urandom_range(0, 3) != 0) ? 1 : 0);
        end
        idle(3);
        repeat (2) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain left=%0d want=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
